// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline register: widths, held-entry layout,
// slot-state encoding and the entry builder used at capture time.
package ex_mem_pkg;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CTRL_W = 5;
   // ctrl layout, MSB first: {reg_write, mem_read, mem_write, mem_to_reg, branch}
   localparam int CTRL_BRANCH = 0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   // One held entry; br_taken is resolved once at capture so MEM sees a flag.
   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] rt_data;
      logic [REG_W-1:0]  write_reg;
      logic [CTRL_W-1:0] ctrl;
      logic              br_taken;
   } payload_t;

   function automatic payload_t make_payload(
      input logic [DATA_W-1:0] result,
      input logic              zero,
      input logic [DATA_W-1:0] rt_data,
      input logic [REG_W-1:0]  write_reg,
      input logic [CTRL_W-1:0] ctrl
   );
      payload_t p;
      p.result    = result;
      p.rt_data   = rt_data;
      p.write_reg = write_reg;
      p.ctrl      = ctrl;
      p.br_taken  = ctrl[CTRL_BRANCH] & zero;
      return p;
   endfunction

   function automatic logic [1:0] occ_of(input state_e s);
      case (s)
         ST_ONE:  return 2'd1;
         ST_FULL: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction
endpackage

// File: rtl/ex_mem_if.sv
// EX-side and MEM-side handshake/payload bundle for the EX/MEM register.
interface ex_mem_if;
   import ex_mem_pkg::*;

   logic              valid_i;
   logic              ready_o;
   logic [DATA_W-1:0] result_i;
   logic              zero_i;
   logic [DATA_W-1:0] rt_data_i;
   logic [REG_W-1:0]  write_reg_i;
   logic [CTRL_W-1:0] ctrl_i;
   logic              flush_i;
   logic              valid_o;
   logic              ready_i;
   logic [DATA_W-1:0] result_o;
   logic [DATA_W-1:0] rt_data_o;
   logic [REG_W-1:0]  write_reg_o;
   logic [CTRL_W-1:0] ctrl_o;
   logic              branch_taken_o;
   logic [1:0]        occupancy_o;

   // Environment side: drives EX payload, flush and MEM ready.
   modport master (
      output valid_i, result_i, zero_i, rt_data_i, write_reg_i, ctrl_i,
             flush_i, ready_i,
      input  ready_o, valid_o, result_o, rt_data_o, write_reg_o, ctrl_o,
             branch_taken_o, occupancy_o
   );

   // Pipeline register side.
   modport slave (
      input  valid_i, result_i, zero_i, rt_data_i, write_reg_i, ctrl_i,
             flush_i, ready_i,
      output ready_o, valid_o, result_o, rt_data_o, write_reg_o, ctrl_o,
             branch_taken_o, occupancy_o
   );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a two-slot skid buffer. The main slot drives
// MEM directly; the skid slot absorbs one entry when MEM stalls so that
// ready_o can be a pure register and never depends on ready_i.
module ex_mem_reg
   import ex_mem_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   ex_mem_if.slave bus
);
   state_e   state;
   payload_t main_q;
   payload_t skid_q;
   logic     ready_q;
   logic     in_xfer;
   logic     out_xfer;
   payload_t incoming;

   assign in_xfer  = bus.valid_i & ready_q;
   assign out_xfer = (state != ST_EMPTY) & bus.ready_i;
   assign incoming = make_payload(bus.result_i, bus.zero_i, bus.rt_data_i,
                                  bus.write_reg_i, bus.ctrl_i);

   // Slot state, payload slots and ready flag advance together in one block.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state   <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
      end else if (bus.flush_i) begin
         // Data fields hold; only the control that MEM acts on is dropped.
         state           <= ST_EMPTY;
         main_q.ctrl     <= '0;
         main_q.br_taken <= 1'b0;
         ready_q         <= 1'b1;
      end else begin
         ready_q <= 1'b1;
         case (state)
            ST_EMPTY: begin
               if (in_xfer) begin
                  main_q <= incoming;
                  state  <= ST_ONE;
               end
            end
            ST_ONE: begin
               case ({in_xfer, out_xfer})
                  2'b11: main_q <= incoming;
                  2'b10: begin
                     skid_q  <= incoming;
                     state   <= ST_FULL;
                     ready_q <= 1'b0;
                  end
                  2'b01: begin
                     // Leaving valid: ctrl must not advertise a write to MEM.
                     state           <= ST_EMPTY;
                     main_q.ctrl     <= '0;
                     main_q.br_taken <= 1'b0;
                  end
                  default: ;
               endcase
            end
            ST_FULL: begin
               if (out_xfer) begin
                  main_q <= skid_q;
                  state  <= ST_ONE;
               end else begin
                  ready_q <= 1'b0;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   assign bus.ready_o        = ready_q;
   assign bus.valid_o        = (state != ST_EMPTY);
   assign bus.occupancy_o    = occ_of(state);
   assign bus.result_o       = main_q.result;
   assign bus.rt_data_o      = main_q.rt_data;
   assign bus.write_reg_o    = main_q.write_reg;
   assign bus.ctrl_o         = main_q.ctrl;
   assign bus.branch_taken_o = main_q.br_taken;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios plus a long random run, all
// checked against an in-order queue model of the pipeline register.
module tb_ex_mem_reg;
   logic clk = 1'b0;
   logic rst;

   ex_mem_if bus ();

   ex_mem_reg dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [31:0] rtd;
      logic [4:0]  wr;
      logic [4:0]  ctrl;
      logic        bt;
   } ent_t;

   ent_t q[$];          // entries held, head is what MEM sees
   ent_t shown;         // expected data fields while invalid (after reset/flush)
   logic data_known = 1'b0;
   logic exp_rdy    = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic ent_t mk(input logic [31:0] res, input logic [4:0] ctrl, input logic z);
      ent_t e;
      e.res  = res;
      e.rtd  = ~res ^ 32'h5a5a_0000;
      e.wr   = res[4:0] ^ 5'h11;
      e.ctrl = ctrl;
      e.bt   = ctrl[0] & z;
      return e;
   endfunction

   // One clock: drive inputs, advance the model, then check after the edge.
   task automatic step(input logic rs, input logic v, input logic r, input logic fl,
                       input ent_t e, input logic z);
      logic acc;
      rst             = rs;
      bus.valid_i     = v;
      bus.ready_i     = r;
      bus.flush_i     = fl;
      bus.result_i    = e.res;
      bus.rt_data_i   = e.rtd;
      bus.write_reg_i = e.wr;
      bus.ctrl_i      = e.ctrl;
      bus.zero_i      = z;
      acc = v && exp_rdy;
      if (!rs) begin
         q.delete();
         shown      = '{32'h0, 32'h0, 5'h0, 5'h0, 1'b0};
         data_known = 1'b1;
         exp_rdy    = 1'b0;
      end else begin
         if (fl) begin
            if (q.size() > 0) begin
               shown      = q[0];
               data_known = 1'b1;
            end
            shown.ctrl = 5'h0;
            shown.bt   = 1'b0;
            q.delete();
         end else begin
            if (q.size() > 0 && r) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (q.size() == 0) data_known = 1'b0;
         end
         exp_rdy = (q.size() < 2);
      end
      @(posedge clk);
      #1;
      chk("valid_o", bus.valid_o, q.size() > 0);
      chk("occupancy_o", bus.occupancy_o, q.size());
      chk("ready_o", bus.ready_o, exp_rdy);
      if (q.size() > 0) begin
         chk("result_o", bus.result_o, q[0].res);
         chk("rt_data_o", bus.rt_data_o, q[0].rtd);
         chk("write_reg_o", bus.write_reg_o, q[0].wr);
         chk("ctrl_o", bus.ctrl_o, q[0].ctrl);
         chk("branch_taken_o", bus.branch_taken_o, q[0].bt);
      end else begin
         chk("ctrl_o_idle", bus.ctrl_o, 0);
         if (data_known) begin
            chk("result_o_hold", bus.result_o, shown.res);
            chk("rt_data_o_hold", bus.rt_data_o, shown.rtd);
            chk("write_reg_o_hold", bus.write_reg_o, shown.wr);
            chk("branch_taken_o_idle", bus.branch_taken_o, shown.bt);
         end
      end
   endtask

   task automatic idle(input logic r);
      step(1'b1, 1'b0, r, 1'b0, mk(32'h0, 5'h0, 1'b0), 1'b0);
   endtask

   initial begin
      ent_t e;
      // Reset, then a single entry with MEM ready.
      step(1'b0, 1'b0, 1'b0, 1'b0, mk(32'h0, 5'h0, 1'b0), 1'b0);
      chk("rst_ready", bus.ready_o, 0);
      step(1'b0, 1'b1, 1'b1, 1'b0, mk(32'h77, 5'h1f, 1'b1), 1'b0);
      idle(1'b0);
      chk("post_rst_ready", bus.ready_o, 1);
      step(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h5, 5'h10, 1'b0), 1'b0);
      chk("first_result", bus.result_o, 32'h5);
      chk("first_occ", bus.occupancy_o, 1);
      idle(1'b1);

      // Stall MEM: A into main, B into skid, C held off.
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h1, 5'h10, 1'b0), 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h2, 5'h08, 1'b0), 1'b0);
      chk("full_ready", bus.ready_o, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h3, 5'h04, 1'b0), 1'b0);
      chk("held_a", bus.result_o, 32'h1);
      idle(1'b1);
      chk("then_b", bus.result_o, 32'h2);
      idle(1'b1);
      chk("drained", bus.valid_o, 0);

      // Branch resolution captured with the entry.
      step(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h40, 5'h01, 1'b1), 1'b1);
      chk("br_taken", bus.branch_taken_o, 1);
      step(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h44, 5'h01, 1'b0), 1'b0);
      chk("br_not_taken", bus.branch_taken_o, 0);
      idle(1'b1);

      // Flush in FULL with a new input offered.
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'ha, 5'h1f, 1'b1), 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'hb, 5'h1f, 1'b1), 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, mk(32'hc, 5'h1f, 1'b1), 1'b1);
      chk("flush_valid", bus.valid_o, 0);
      chk("flush_ctrl", bus.ctrl_o, 0);
      chk("flush_occ", bus.occupancy_o, 0);
      chk("flush_ready", bus.ready_o, 1);
      chk("flush_res_hold", bus.result_o, 32'ha);

      // Reset in FULL.
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'hd, 5'h1f, 1'b1), 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'he, 5'h1f, 1'b1), 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, mk(32'hf, 5'h1f, 1'b1), 1'b1);
      chk("rst_full_res", bus.result_o, 0);
      chk("rst_full_bt", bus.branch_taken_o, 0);
      chk("rst_full_ready", bus.ready_o, 0);
      idle(1'b0);
      chk("rst_full_ready_after", bus.ready_o, 1);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 10000; i++) begin
         logic z;
         z = 1'($urandom);
         e = mk($urandom, 5'($urandom), z);
         e.rtd = $urandom;
         e.wr  = 5'($urandom);
         step(($urandom_range(0, 499) != 0), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 49) == 0), e, z);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_i  in  1  reset, synchronous and active-low.
REQ-003 valid_i  in  1  EX stage holds a valid ALU result this cycle.
REQ-004 ready_o  out  1  block accepts EX payload this cycle; registered output.
REQ-005 result_i  in  32  ALU result.
REQ-006 zero_i  in  1  ALU zero flag.
REQ-007 rt_data_i  in  32  store data (rt operand after forwarding).
REQ-008 write_reg_i  in  5  destination register number.
REQ-009 ctrl_i  in  5  {reg_write, mem_read, mem_write, mem_to_reg, branch}, MSB first.
REQ-010 flush_i  in  1  discard all held and incoming entries.
REQ-011 valid_o  out  1  MEM-side payload valid.
REQ-012 ready_i  in  1  MEM stage consumes payload this cycle.
REQ-013 result_o, rt_data_o (32), write_reg_o (5), ctrl_o (5)  out  registered payload.
REQ-014 branch_taken_o  out  1  registered branch AND zero of the held entry.
REQ-015 occupancy_o  out  2  entries held, 0..2.

Function
REQ-016 Input transfer occurs when valid_i and ready_o are both 1; output transfer occurs when valid_o and ready_i are both 1.
REQ-017 Storage: two slots, main (drives outputs) and skid; latency from accepted input to valid_o is 1 cycle when main is empty.
REQ-018 States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid).
REQ-019 EMPTY + input transfer -> ONE, main loads payload.
REQ-020 ONE + input + output transfer -> ONE, main reloads with new payload, no bubble.
REQ-021 ONE + input, no output -> FULL, skid loads payload, main holds.
REQ-022 ONE + output, no input -> EMPTY.
REQ-023 FULL + output -> ONE, main loads skid contents; FULL without output holds.
REQ-024 ready_o SHALL be 1 exactly when the skid slot is empty; no input is accepted in FULL.
REQ-025 All outputs SHALL stay stable while valid_o=1 and ready_i=0.
REQ-026 branch_taken_o SHALL equal ctrl branch bit AND zero_i of the same accepted entry, captured with it.
REQ-027 flush_i=1: next state EMPTY regardless of valid_i/ready_i; incoming payload discarded; ctrl_o and branch_taken_o cleared to 0; result_o, rt_data_o, write_reg_o hold.
REQ-028 flush_i has priority over every transfer in the same cycle; an output transfer in that cycle still counts as consumed by MEM.
REQ-029 valid_o=0 implies ctrl_o=0, so MEM never sees reg_write or mem_write from an invalid entry.
REQ-030 Payload SHALL pass through bit-exact; no arithmetic on data fields.

Reset
REQ-031 rst_i=0 at a clock edge: state EMPTY, valid_o=0, ready_o=0, occupancy_o=0, all payload outputs and branch_taken_o 0, skid cleared.
REQ-032 First cycle after rst_i returns to 1: ready_o=1.
REQ-033 Reset overrides flush_i and all transfers, including mid-FULL.

Structure
REQ-034 Shared package ex_mem_pkg holds DATA_W=32, REG_W=5, CTRL_W=5, the payload struct typedef and the 3-state enum.
REQ-035 Single module; no sub-module, since the two slots are plain registers sharing one next-state block.

Verification
REQ-036 Reset then valid_i=1 result_i=0x0000_0005 ready_i=1 -> next cycle valid_o=1 result_o=0x0000_0005, occupancy_o=1.
REQ-037 ready_i=0, three back-to-back inputs A=1, B=2, C=3 -> A in main, B in skid, ready_o=0 after B, C held off; ready_i=1 for 2 cycles -> outputs A then B, no loss.
REQ-038 ctrl_i branch=1 zero_i=1 -> branch_taken_o=1; branch=1 zero_i=0 -> 0.
REQ-039 In FULL, assert flush_i with valid_i=1 -> next cycle valid_o=0, ctrl_o=0, occupancy_o=0, ready_o=1.
REQ-040 In FULL, rst_i=0 for one cycle -> all outputs 0, ready_o=0; following cycle ready_o=1.
REQ-041 Random valid_i/ready_i, 10,000 cycles -> output sequence equals accepted input sequence, valid_o never drops without a transfer or flush.
